i2c_temp_target: RTL
====================

// Module: i2c_temp_target
// PURPOSE
//   I2C target (responder) that emulates the on-board temperature sensor at 7-bit address 0x4B.
//   Returns a 16-bit temperature word supplied by fabric logic, so the existing I2C host can be exercised with no real sensor.
//   Sits on the same open-drain sda/scl pair. Also serves as a bench model for host-side logic.
// PARAMETERS
//   DEV_ADDR   7'h4B   7-bit target address matched after START
//   ID_VALUE   8'hCB   value returned at register pointer 0x0B
// PORTS
//   clk        in     1   system clock, 100 MHz; must be >= 20x SCL frequency
//   rst_n      in     1   asynchronous active-low reset
//   scl        in     1   I2C clock from host; target never stretches
//   sda        inout  1   open-drain data: drives 0 or z, never drives 1
//   temp_in    in     16  temperature word {MSB,LSB}, 13-bit value left-justified
//   busy       out    1   high from address match until STOP or next START
//   rd_done    out    1   1-cycle pulse when host ACKs or NACKs a byte this target sent
//   ptr        out    8   current register pointer, for debug
// BEHAVIOUR
//   Reset: sda released (z), busy=0, rd_done=0, ptr=0x00, state=IDLE. Async assert releases sda in the same cycle.
//   Input conditioning:
//     - scl and sda each pass through 2-flop synchronisers.
//     - Edges are detected on the synchronised copies.
//     - No glitch filter.
//   Bus conditions (synchronised signals):
//     - START: sda falls while scl is high.
//     - STOP: sda rises while scl is high.
//     - Both are recognised in every state, including mid-byte.
//     - START (including repeated START): go to ADDR, bit count 0, release sda.
//     - STOP: go to IDLE, release sda, busy=0.
//   Timing rules:
//     - Sample sda on scl rising edge.
//     - Change sda drive only on scl falling edge, at most 3 clk cycles later.
//   States:
//     IDLE   : wait for START.
//     ADDR   : shift 8 bits MSB first (7 address bits, then R/W).
//              Match: busy=1, go to A_ACK.
//              Mismatch: go to IDLE, never drive sda; wait for next START.
//     A_ACK  : drive sda=0 for the 9th clock.
//              Read (R/W=1): capture snapshot=temp_in, load first tx byte, go to TX.
//              Write: go to RX.
//     TX     : on each scl fall, drive the current bit MSB first.
//              A 1 bit releases sda; a 0 bit drives it low.
//              After 8 bits, release sda and go to H_ACK.
//     H_ACK  : sample sda on the 9th scl rise; pulse rd_done; ptr increments (8-bit wrap 0xFF->0x00).
//              ACK (0): load next byte, go to TX.
//              NACK (1): go to WAIT.
//     RX     : shift 8 bits, then go to R_ACK.
//     R_ACK  : drive sda=0 for the 9th clock.
//              First data byte of a write transaction loads ptr.
//              Later data bytes are ACKed and discarded.
//              Return to RX.
//     WAIT   : sda released; wait for STOP or START.
//   Register map (read data at ptr):
//     0x00 = snapshot[15:8]; 0x01 = snapshot[7:0]; 0x0B = ID_VALUE; all others = 0x00.
//   Coherency: snapshot is taken once per read transaction at A_ACK. Changes on temp_in mid-transfer must not mix MSB and LSB.
//   Host driving sda high while the target drives low is a bus condition the target ignores; the data it sends is not altered.
// TESTING
//   1. ptr=0, temp_in=16'h0C80, host reads 2 bytes from 0x4B:
//      -> address ACKed; bytes 0x0C, 0x80; rd_done pulses twice.
//   2. Host addresses 0x48 (read):
//      -> sda never driven low by the target; busy stays 0; state returns to IDLE.
//   3. Write pointer 0x0B, repeated START, read 1 byte with NACK, then STOP:
//      -> pointer byte ACKed; reads 0xCB; busy=0 after STOP.
//   4. Read transaction, temp_in changes 16'h0C80 -> 16'h1900 after MSB is sent:
//      -> bytes 0x0C, 0x80, from the snapshot.
//   5. rst_n low while target drives an ACK low:
//      -> sda goes z in the same cycle; ptr=0x00.
//      -> after release, the next full read works.
//   6. STOP issued after 4 bits of a TX byte:
//      -> sda released, state IDLE, busy=0; no rd_done pulse.

Source files
------------

// File: rtl/i2c_temp_target_if.sv
// Fabric-side view of the emulated temperature sensor: the temperature word it
// serves, plus status and debug outputs. The fabric drives the word and observes the status.
interface i2c_temp_target_if;
  logic [15:0] temp_in;
  logic        busy;
  logic        rd_done;
  logic [7:0]  ptr;

  modport master (output temp_in, input busy, rd_done, ptr);
  modport slave  (input temp_in, output busy, rd_done, ptr);
endinterface

// File: rtl/i2c_temp_target.sv
// I2C target that answers at DEV_ADDR like the on-board temperature sensor and
// serves a fabric-supplied 16-bit temperature word through a small register map.
module i2c_temp_target #(
  parameter logic [6:0] DEV_ADDR = 7'h4B,
  parameter logic [7:0] ID_VALUE = 8'hCB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  inout  wire               sda,
  i2c_temp_target_if.slave  fab
);
  typedef enum logic [2:0] {IDLE, ADDR, A_ACK, TX, H_ACK, RX, R_ACK, WAIT} state_t;

  state_t      state_reg, state_next;
  logic        scl_s1_reg, scl_s2_reg, scl_d_reg;
  logic        sda_s1_reg, sda_s2_reg, sda_d_reg;
  logic [3:0]  bit_cnt_reg;
  logic [7:0]  shift_reg, tx_reg, ptr_reg;
  logic [15:0] snap_reg;
  logic        sda_oe_reg, rd_done_reg, host_nack_reg, first_byte_reg;
  logic        scl_rise, scl_fall, start_det, stop_det, addr_match, byte_done;
  logic [7:0]  rd_byte;

  // Open drain: only ever pull low or let go.
  assign sda = sda_oe_reg ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_reg <= 1'b1;
      scl_s2_reg <= 1'b1;
      scl_d_reg  <= 1'b1;
      sda_s1_reg <= 1'b1;
      sda_s2_reg <= 1'b1;
      sda_d_reg  <= 1'b1;
    end else begin
      scl_s1_reg <= scl;
      scl_s2_reg <= scl_s1_reg;
      scl_d_reg  <= scl_s2_reg;
      sda_s1_reg <= sda;
      sda_s2_reg <= sda_s1_reg;
      sda_d_reg  <= sda_s2_reg;
    end
  end

  assign scl_rise   = scl_s2_reg & ~scl_d_reg;
  assign scl_fall   = ~scl_s2_reg & scl_d_reg;
  assign start_det  = scl_s2_reg & scl_d_reg & sda_d_reg & ~sda_s2_reg;
  assign stop_det   = scl_s2_reg & scl_d_reg & ~sda_d_reg & sda_s2_reg;
  assign addr_match = (shift_reg[7:1] == DEV_ADDR);
  assign byte_done  = (bit_cnt_reg == 4'd8);

  always_comb begin
    rd_byte = 8'h00;
    case (ptr_reg)
      8'h00:   rd_byte = snap_reg[15:8];
      8'h01:   rd_byte = snap_reg[7:0];
      8'h0B:   rd_byte = ID_VALUE;
      default: rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (start_det) begin
      state_next = ADDR;
    end else if (stop_det) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        ADDR:    if (scl_fall && byte_done) state_next = addr_match ? A_ACK : IDLE;
        A_ACK:   if (scl_fall) state_next = shift_reg[0] ? TX : RX;
        TX:      if (scl_fall && byte_done) state_next = H_ACK;
        H_ACK:   if (scl_fall) state_next = host_nack_reg ? WAIT : TX;
        RX:      if (scl_fall && byte_done) state_next = R_ACK;
        R_ACK:   if (scl_fall) state_next = RX;
        default: state_next = state_reg;
      endcase
    end
  end

  // Datapath: sda drive only changes on a detected scl fall, bits sampled on a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg    <= 4'd0;
      shift_reg      <= 8'h00;
      tx_reg         <= 8'h00;
      ptr_reg        <= 8'h00;
      snap_reg       <= 16'h0000;
      sda_oe_reg     <= 1'b0;
      rd_done_reg    <= 1'b0;
      host_nack_reg  <= 1'b0;
      first_byte_reg <= 1'b0;
    end else begin
      rd_done_reg <= 1'b0;
      if (start_det) begin
        bit_cnt_reg    <= 4'd0;
        sda_oe_reg     <= 1'b0;
        first_byte_reg <= 1'b1;
      end else if (stop_det) begin
        sda_oe_reg <= 1'b0;
      end else begin
        case (state_reg)
          ADDR, RX: begin
            if (scl_rise) begin
              shift_reg   <= {shift_reg[6:0], sda_s2_reg};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall && byte_done) begin
              if (state_reg == RX) begin
                sda_oe_reg <= 1'b1;
              end else if (addr_match) begin
                sda_oe_reg <= 1'b1;
                if (shift_reg[0]) snap_reg <= fab.temp_in;
              end
            end
          end
          A_ACK: begin
            if (scl_fall) begin
              if (shift_reg[0]) begin
                tx_reg      <= rd_byte;
                sda_oe_reg  <= ~rd_byte[7];
                bit_cnt_reg <= 4'd1;
              end else begin
                sda_oe_reg  <= 1'b0;
                bit_cnt_reg <= 4'd0;
              end
            end
          end
          TX: begin
            if (scl_fall) begin
              if (byte_done) begin
                sda_oe_reg <= 1'b0;
              end else begin
                sda_oe_reg  <= ~tx_reg[6];
                tx_reg      <= {tx_reg[6:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end
          H_ACK: begin
            if (scl_rise) begin
              host_nack_reg <= sda_s2_reg;
              rd_done_reg   <= 1'b1;
              ptr_reg       <= ptr_reg + 8'd1;
            end else if (scl_fall && !host_nack_reg) begin
              tx_reg      <= rd_byte;
              sda_oe_reg  <= ~rd_byte[7];
              bit_cnt_reg <= 4'd1;
            end
          end
          R_ACK: begin
            if (scl_fall) begin
              sda_oe_reg  <= 1'b0;
              bit_cnt_reg <= 4'd0;
              if (first_byte_reg) begin
                ptr_reg        <= shift_reg;
                first_byte_reg <= 1'b0;
              end
            end
          end
          default: sda_oe_reg <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    fab.busy    = !(state_reg == IDLE || state_reg == ADDR);
    fab.rd_done = rd_done_reg;
    fab.ptr     = ptr_reg;
  end
endmodule
